dtc_vote_accum: RTL and testbench



---
 rtl/dtc_vote_pkg.sv | 19 +
 rtl/dtc_vote_argmax.sv | 41 ++++
 rtl/dtc_vote_accum.sv | 136 +++++++++++++
 tb/tb_dtc_vote_accum.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtc_vote_pkg.sv
// dtc_vote_pkg: shared types and constants for the windowed majority-vote stage.
//   CLS_W        width of a class code
//   N_CLASSES    number of distinct classes (2**CLS_W)
//   vote_state_e FSM states of dtc_vote_accum
//   cls_t        class-code type
package dtc_vote_pkg;

    localparam int unsigned CLS_W     = 3;
    localparam int unsigned N_CLASSES = 2 ** CLS_W;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        VOTE  = 2'd1,
        EMIT  = 2'd2
    } vote_state_e;

    typedef logic [CLS_W-1:0] cls_t;

endpackage : dtc_vote_pkg

// File: rtl/dtc_vote_argmax.sv
// dtc_vote_argmax: combinational balanced compare tree returning the class with
// the largest count. On equal counts the lower class code wins.
//   cnt      in   N_CLASSES packed counters, entry i is the count of class i
//   max_idx  out  winning class code
//   max_cnt  out  count of the winning class
module dtc_vote_argmax
    import dtc_vote_pkg::*;
#(
    parameter int unsigned CNT_W = 5
) (
    input  logic [N_CLASSES-1:0][CNT_W-1:0] cnt,
    output logic [CLS_W-1:0]                max_idx,
    output logic [CNT_W-1:0]                max_cnt
);

    // Level l holds N_CLASSES>>l survivors; level CLS_W is the single winner.
    for (genvar l = 0; l <= CLS_W; l++) begin : g_lvl
        logic [CNT_W-1:0] val [N_CLASSES >> l];
        logic [CLS_W-1:0] idx [N_CLASSES >> l];

        if (l == 0) begin : g_leaf
            for (genvar k = 0; k < N_CLASSES; k++) begin : g_node
                assign val[k] = cnt[k];
                assign idx[k] = CLS_W'(k);
            end
        end else begin : g_cmp
            for (genvar k = 0; k < (N_CLASSES >> l); k++) begin : g_node
                // Left operand always carries the lower class codes, so only a
                // strictly larger right count may displace it.
                logic take_right;
                assign take_right = g_lvl[l-1].val[2*k+1] > g_lvl[l-1].val[2*k];
                assign val[k] = take_right ? g_lvl[l-1].val[2*k+1] : g_lvl[l-1].val[2*k];
                assign idx[k] = take_right ? g_lvl[l-1].idx[2*k+1] : g_lvl[l-1].idx[2*k];
            end
        end
    end

    assign max_idx = g_lvl[CLS_W].idx[0];
    assign max_cnt = g_lvl[CLS_W].val[0];

endmodule : dtc_vote_argmax

// File: rtl/dtc_vote_accum.sv
// dtc_vote_accum: accumulates per-class prediction counts over a window of
// WINDOW accepted predictions and emits the most frequent class.
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               synchronous abort of the current window / pending result
//   in_valid/in_ready   prediction handshake, in_class is the predicted class
//   out_valid/out_ready result handshake, out_class is the winning class
//   out_conf            winning count (only when DTC_VOTE_CONF_EN is defined)
// Optional feature macro: DTC_VOTE_CONF_EN
module dtc_vote_accum
    import dtc_vote_pkg::*;
#(
    parameter  int unsigned WINDOW = 16,
    localparam int unsigned CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CLS_W-1:0] in_class,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef DTC_VOTE_CONF_EN
    output logic [CNT_W-1:0] out_conf,
`endif
    output logic [CLS_W-1:0] out_class
);

    vote_state_e                     state_q;
    vote_state_e                     state_d;
    logic [N_CLASSES-1:0][CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0]                smp_q;

    logic             accept_c;
    logic             last_c;
    logic             load_c;
    logic             release_c;
    logic [CLS_W-1:0] arg_idx;
    logic [CNT_W-1:0] arg_cnt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear overrides everything.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM:   if (last_c)    state_d = VOTE;
                VOTE:                   state_d = EMIT;
                EMIT:    if (release_c) state_d = ACCUM;
                default:                state_d = ACCUM;
            endcase
        end
    end

    // Datapath strobes decoded from state and handshakes.
    always_comb begin
        accept_c  = 1'b0;
        last_c    = 1'b0;
        load_c    = 1'b0;
        release_c = 1'b0;
        if (!clear) begin
            accept_c  = in_valid && (state_q == ACCUM);
            last_c    = accept_c && (smp_q == CNT_W'(WINDOW - 1));
            load_c    = (state_q == VOTE);
            release_c = (state_q == EMIT) && out_ready;
        end
    end

    // Per-class counters and sample counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            smp_q <= '0;
        end else if (clear || release_c) begin
            cnt_q <= '0;
            smp_q <= '0;
        end else if (accept_c) begin
            cnt_q[in_class] <= cnt_q[in_class] + CNT_W'(1);
            smp_q           <= smp_q + CNT_W'(1);
        end
    end

    dtc_vote_argmax #(
        .CNT_W (CNT_W)
    ) u_argmax (
        .cnt     (cnt_q),
        .max_idx (arg_idx),
        .max_cnt (arg_cnt)
    );

    // Handshake flags registered from the next state so they track state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_d == ACCUM);
            out_valid <= (state_d == EMIT);
        end
    end

    // Result captured in the single VOTE cycle, held through EMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_class <= '0;
        end else if (load_c) begin
            out_class <= arg_idx;
        end
    end

`ifdef DTC_VOTE_CONF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_conf <= '0;
        end else if (load_c) begin
            out_conf <= arg_cnt;
        end
    end
`endif

    // A completed window always has a winner with at least one vote.
    a_winner_nonzero : assert property (
        @(posedge clk) disable iff (!rst_n) (state_q == VOTE) |-> (arg_cnt != '0)
    );

endmodule : dtc_vote_accum

// File: tb/tb_dtc_vote_accum.sv
module tb_dtc_vote_accum;

    localparam int unsigned WIN   = 16;
    localparam int unsigned CNT_W = $clog2(WIN + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_class;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_class;
    logic [CNT_W-1:0] conf_w;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dtc_vote_accum #(
        .WINDOW (WIN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_class  (in_class),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef DTC_VOTE_CONF_EN
        .out_conf  (conf_w),
`endif
        .out_class (out_class)
    );

`ifndef DTC_VOTE_CONF_EN
    assign conf_w = '0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the window as plain counts; a finished window waits one cycle
    // for the vote, then is offered until taken.
    int m_counts [8];
    int m_n;
    bit m_busy;
    bit m_vld;
    int m_cls;
    int m_conf;

    task automatic model_reset();
        for (int c = 0; c < 8; c++) m_counts[c] = 0;
        m_n    = 0;
        m_busy = 0;
        m_vld  = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
            m_cls  = 0;
            m_conf = 0;
        end else if (clear) begin
            model_reset();
        end else if (m_vld) begin
            if (out_ready) model_reset();
        end else if (m_busy) begin
            m_vld = 1;
        end else if (in_valid) begin
            m_counts[in_class]++;
            m_n++;
            if (m_n == WIN) begin
                m_busy = 1;
                m_cls  = 0;
                for (int c = 1; c < 8; c++)
                    if (m_counts[c] > m_counts[m_cls]) m_cls = c;
                m_conf = m_counts[m_cls];
            end
        end
    end

    // Cycle-by-cycle compare against the model.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            chk("rst_in_ready", int'(in_ready), 1);
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_out_class", int'(out_class), 0);
            chk("rst_out_conf", int'(conf_w), 0);
        end else begin
            chk("in_ready", int'(in_ready), int'(!m_busy));
            chk("out_valid", int'(out_valid), int'(m_vld));
            if (m_vld) begin
                chk("out_class", int'(out_class), m_cls);
`ifdef DTC_VOTE_CONF_EN
                chk("out_conf", int'(conf_w), m_conf);
`endif
            end
        end
    end

    // Results actually handed over by the DUT.
    int got_cls [$];
    int got_conf [$];

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_cls.push_back(int'(out_class));
            got_conf.push_back(int'(conf_w));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send1(input logic [2:0] c, input int bub);
        bit ok;
        ok = 0;
        if (bub > 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            repeat (bub - 1) @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_class = c;
        for (int k = 0; k < 64; k++) begin
            @(posedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        chk("accept_wait", int'(ok), 1);
    endtask

    task automatic send_n(input logic [2:0] c, input int n);
        for (int i = 0; i < n; i++) send1(c, 0);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input int exp_cls, input int exp_conf);
        bit ok;
        int gc;
        int gf;
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            if (got_cls.size() > 0) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk({name, "_present"}, int'(ok), 1);
        if (ok) begin
            gc = got_cls.pop_front();
            gf = got_conf.pop_front();
            chk({name, "_class"}, gc, exp_cls);
`ifdef DTC_VOTE_CONF_EN
            chk({name, "_conf"}, gf, exp_conf);
`endif
        end
    endtask

    logic [2:0] mix [16] = '{3'd1, 3'd4, 3'd7, 3'd4, 3'd1, 3'd7, 3'd4, 3'd1,
                             3'd4, 3'd7, 3'd1, 3'd4, 3'd7, 3'd1, 3'd4, 3'd7};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_class  = 3'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        rst_n = 1'b1;

        // 16 x class 3, result two cycles after the last accept.
        send_n(3'd3, 16);
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_vote_cycle", int'(out_valid), 0);
        chk("lat_vote_in_ready", int'(in_ready), 0);
        @(negedge clk);
        chk("lat_emit_cycle", int'(out_valid), 1);
        wait_result("all3", 3, 16);

        // Tie between classes 2 and 5 goes to the lower code.
        send_n(3'd2, 8);
        send_n(3'd5, 8);
        idle();
        wait_result("tie25", 2, 8);

        // Back-pressured result with a held input sample.
        out_ready = 1'b0;
        send_n(3'd7, 16);
        fork
            send1(3'd0, 0);
            begin
                repeat (12) @(negedge clk);
                chk("stall_no_result", got_cls.size(), 0);
                chk("stall_in_ready", int'(in_ready), 0);
                out_ready = 1'b1;
            end
        join
        idle();
        wait_result("stall7", 7, 16);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;

        // Clear aborts 7 x class 1; a sample offered with clear is dropped.
        send_n(3'd1, 7);
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_class = 3'd1;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        send_n(3'd6, 16);
        idle();
        wait_result("after_clear", 6, 16);
        repeat (4) @(negedge clk);
        chk("clear_single_result", got_cls.size(), 0);

        // Reset mid-window after 9 x class 4.
        send_n(3'd4, 9);
        idle();
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_class", int'(out_class), 0);
        chk("midrst_out_conf", int'(conf_w), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_n(3'd0, 16);
        idle();
        wait_result("after_rst", 0, 16);

        // Mixed window with random bubbles: 5 x 1, 6 x 4, 5 x 7.
        for (int i = 0; i < 16; i++) send1(mix[i], int'($urandom_range(0, 2)));
        idle();
        wait_result("mixed", 4, 6);

        repeat (5) @(negedge clk);
        chk("no_extra_results", got_cls.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_dtc_vote_accum
